// File: rtl/vc_meta_plru_store_pkg.sv
// Shared types and helpers for the victim-cache metadata store: flush FSM states,
// tree-PLRU touch/victim walks and the first-invalid priority encoder.
package vc_meta_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} flush_state_e;

  // Helpers work on the largest supported tree; callers zero-extend and pass idx_w.
  localparam int MAX_IDX_W = 8;
  localparam int MAX_SIZE  = 1 << MAX_IDX_W;

  typedef logic [MAX_SIZE-2:0]  plru_tree_t;
  typedef logic [MAX_IDX_W-1:0] idx_t;

  function automatic plru_tree_t plru_touch(input plru_tree_t tree, input idx_t idx,
                                            input int idx_w);
    plru_tree_t t;
    int         node;
    logic       b;
    t    = tree;
    node = 0;
    for (int lvl = 0; lvl < MAX_IDX_W; lvl++) begin
      if (lvl < idx_w) begin
        b       = idx[idx_w-1-lvl];
        t[node] = ~b;
        node    = 2 * node + 1 + int'(b);
      end
    end
    return t;
  endfunction

  function automatic idx_t plru_victim(input plru_tree_t tree, input int idx_w);
    idx_t v;
    int   node;
    logic b;
    v    = '0;
    node = 0;
    for (int lvl = 0; lvl < MAX_IDX_W; lvl++) begin
      if (lvl < idx_w) begin
        b              = tree[node];
        v[idx_w-1-lvl] = b;
        node           = 2 * node + 1 + int'(b);
      end
    end
    return v;
  endfunction

  // Scanning from the top down lets the lowest invalid index win.
  function automatic idx_t first_invalid(input logic [MAX_SIZE-1:0] valid, input int size);
    idx_t v;
    v = '0;
    for (int i = MAX_SIZE - 1; i >= 0; i--) begin
      if (i < size && !valid[i]) v = idx_t'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/vc_meta_plru_store_plru_tree.sv
// Tree-PLRU state for the victim cache: one touch per cycle, victim leaf decoded
// combinationally from the registered tree.
module vc_plru_tree
  import vc_meta_pkg::*;
#(
  parameter int VC_SIZE = 8,
  parameter int IDX_W   = $clog2(VC_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] victim_idx
);

  logic [VC_SIZE-2:0] tree_q;
  plru_tree_t         tree_ext;
  plru_tree_t         tree_nxt;
  idx_t               victim_ext;
  logic               unused_ext_bits;

  always_comb begin
    tree_ext                = '0;
    tree_ext[VC_SIZE-2:0]   = tree_q;
    tree_nxt                = plru_touch(tree_ext, idx_t'(touch_idx), IDX_W);
    victim_ext              = plru_victim(tree_ext, IDX_W);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tree_q <= '0;
    end else if (touch_en) begin
      tree_q <= tree_nxt[VC_SIZE-2:0];
    end
  end

  assign victim_idx      = victim_ext[IDX_W-1:0];
  assign unused_ext_bits = ^{tree_nxt, victim_ext};

endmodule

// File: rtl/vc_meta_plru_store.sv
// Victim-cache metadata store: valid/dirty arrays, PLRU replacement and a dirty-flush
// walker that streams dirty indices to writeback over valid/ready.
module vc_meta_plru_store
  import vc_meta_pkg::*;
#(
  parameter int VC_SIZE = 8,
  parameter int IDX_W   = $clog2(VC_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_en,
  input  logic [IDX_W-1:0]   fill_idx,
  input  logic               fill_dirty,
  input  logic               wr_hit_en,
  input  logic [IDX_W-1:0]   wr_hit_idx,
  input  logic               rd_hit_en,
  input  logic [IDX_W-1:0]   rd_hit_idx,
  input  logic               inval_en,
  input  logic [IDX_W-1:0]   inval_idx,
  output logic [VC_SIZE-1:0] valid_vec,
  output logic [VC_SIZE-1:0] dirty_vec,
  output logic [IDX_W-1:0]   victim_idx,
  output logic               victim_dirty,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               wb_valid,
  output logic [IDX_W-1:0]   wb_idx,
  input  logic               wb_ready,
  output logic               flush_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_SIZE - 1);

  flush_state_e          state;
  logic [IDX_W-1:0]      ptr;
  logic [VC_SIZE-1:0]    valid_q;
  logic [VC_SIZE-1:0]    dirty_q;
  logic [VC_SIZE-1:0]    valid_nxt;
  logic [VC_SIZE-1:0]    dirty_nxt;
  logic                  busy;
  logic                  wb_accept;
  logic                  last_ptr;
  logic                  touch_en;
  logic [IDX_W-1:0]      touch_idx;
  logic [IDX_W-1:0]      plru_idx;
  logic [MAX_SIZE-1:0]   valid_ext;
  idx_t                  first_inv_ext;
  logic                  unused_inv_bits;

  assign busy      = (state != IDLE);
  assign wb_accept = (state == EMIT) && wb_ready;
  assign last_ptr  = (ptr == LAST_IDX);

  // Single touch per cycle; fill and wr_hit are locked out while the walker runs.
  always_comb begin
    touch_en  = 1'b0;
    touch_idx = rd_hit_idx;
    if (!busy && fill_en) begin
      touch_en  = 1'b1;
      touch_idx = fill_idx;
    end else if (!busy && wr_hit_en) begin
      touch_en  = 1'b1;
      touch_idx = wr_hit_idx;
    end else if (rd_hit_en) begin
      touch_en  = 1'b1;
      touch_idx = rd_hit_idx;
    end
  end

  // Write order gives inval > fill > wr_hit when they land on the same entry.
  always_comb begin
    valid_nxt = valid_q;
    dirty_nxt = dirty_q;
    if (!busy) begin
      if (wr_hit_en) dirty_nxt[wr_hit_idx] = 1'b1;
      if (fill_en) begin
        valid_nxt[fill_idx] = 1'b1;
        dirty_nxt[fill_idx] = fill_dirty;
      end
      if (inval_en) begin
        valid_nxt[inval_idx] = 1'b0;
        dirty_nxt[inval_idx] = 1'b0;
      end
    end
    if (wb_accept) dirty_nxt[ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      dirty_q <= dirty_nxt;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= SCAN;
            ptr   <= '0;
          end
        end
        SCAN: begin
          if (valid_q[ptr] && dirty_q[ptr]) state <= EMIT;
          else if (last_ptr)                state <= DONE;
          else                              ptr   <= ptr + 1'b1;
        end
        EMIT: begin
          if (wb_ready) begin
            if (last_ptr) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  vc_plru_tree #(
    .VC_SIZE (VC_SIZE),
    .IDX_W   (IDX_W)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .touch_en   (touch_en),
    .touch_idx  (touch_idx),
    .victim_idx (plru_idx)
  );

  always_comb begin
    valid_ext              = '1;
    valid_ext[VC_SIZE-1:0] = valid_q;
    first_inv_ext          = first_invalid(valid_ext, VC_SIZE);
  end

  assign unused_inv_bits = ^first_inv_ext;

  assign victim_idx   = (&valid_q) ? plru_idx : first_inv_ext[IDX_W-1:0];
  assign victim_dirty = valid_q[victim_idx] & dirty_q[victim_idx];
  assign valid_vec    = valid_q;
  assign dirty_vec    = dirty_q;
  assign flush_busy   = busy;
  assign wb_valid     = (state == EMIT);
  assign wb_idx       = ptr;
  assign flush_done   = (state == DONE);

endmodule
